// File: rtl/apb_arb_sched.sv
// Grant scheduler for the shared APB slave port. Two priority levels with
// round-robin inside each level, a bounded high-priority burst so low-priority
// masters are not starved, and a per-transfer watchdog that aborts a grant
// whose slave never completes.
module apb_arb_sched #(
  parameter int unsigned NUM_REQ        = 16,
  parameter int unsigned MAX_HP_BURST   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         hp_mask_i,
  input  logic                       done_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       busy_o,
  output logic                       timeout_o,
  output logic [$clog2(NUM_REQ)-1:0] timeout_idx_o,
  output logic [CNT_WIDTH-1:0]       timeout_cnt_o
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned BurstW = $clog2(MAX_HP_BURST + 1);
  localparam int unsigned WdW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_REQ - 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_HP_BURST);
  // Only meaningful when the watchdog is enabled.
  localparam logic [WdW-1:0]    WdLast   = WdW'(TIMEOUT_CYCLES - 1);
  localparam bit                WdEn     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IdxW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]     hp_ptr_q, hp_ptr_d;
  logic [IdxW-1:0]     lp_ptr_q, lp_ptr_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic                to_q, to_d;
  logic [IdxW-1:0]     to_idx_q, to_idx_d;
  logic [CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;

  logic [NUM_REQ-1:0]  h_vec, l_vec;
  logic                pick_low;
  logic [IdxW-1:0]     win_h, win_l, win, win_next;
  logic                wd_expire;

  // First set bit at or after ptr, wrapping; lowest set bit if none above ptr.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                              input logic [IdxW-1:0]    ptr);
    logic [IdxW-1:0] first_any;
    logic [IdxW-1:0] first_hi;
    logic            hi_found;
    first_any = '0;
    first_hi  = '0;
    hi_found  = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (vec[k]) begin
        first_any = IdxW'(k);
        if (k >= int'(ptr)) begin
          first_hi = IdxW'(k);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? first_hi : first_any;
  endfunction

  // Level selection and winner for the current request snapshot.
  always_comb begin
    h_vec    = req_i & hp_mask_i;
    l_vec    = req_i & ~hp_mask_i;
    pick_low = (l_vec != '0) && ((h_vec == '0) || (burst_q == BurstMax));
    win_h    = rr_pick(h_vec, hp_ptr_q);
    win_l    = rr_pick(l_vec, lp_ptr_q);
    win      = pick_low ? win_l : win_h;
    win_next = (win == LastIdx) ? '0 : win + 1'b1;
    wd_expire = WdEn && (state_q == StGrant) && !done_i && (wd_q == WdLast);
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant on any request, release on done or watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (|req_i) state_d = StGrant;
      StGrant: if (done_i || wd_expire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; everything is driven straight from registers.
  always_comb begin
    busy_o        = (state_q == StGrant);
    gnt_o         = gnt_q;
    gnt_idx_o     = gnt_idx_q;
    timeout_o     = to_q;
    timeout_idx_o = to_idx_q;
    timeout_cnt_o = to_cnt_q;
  end

  // Datapath next-state: grant load, pointers, burst count, watchdog, abort record.
  always_comb begin
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    hp_ptr_d  = hp_ptr_q;
    lp_ptr_d  = lp_ptr_q;
    burst_d   = burst_q;
    wd_d      = wd_q;
    to_d      = 1'b0;
    to_idx_d  = to_idx_q;
    to_cnt_d  = to_cnt_q;
    if (state_q == StIdle) begin
      if (|req_i) begin
        gnt_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
        gnt_idx_d = win;
        wd_d      = '0;
        if (pick_low) begin
          lp_ptr_d = win_next;
          burst_d  = '0;
        end else begin
          hp_ptr_d = win_next;
          // Burst only accrues while some low-priority master is waiting.
          if (l_vec == '0) begin
            burst_d = '0;
          end else if (burst_q != BurstMax) begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
    end else begin
      if (done_i) begin
        gnt_d     = '0;
        gnt_idx_d = '0;
      end else if (wd_expire) begin
        gnt_d     = '0;
        gnt_idx_d = '0;
        to_d      = 1'b1;
        to_idx_d  = gnt_idx_q;
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 1'b1;
      end else if (WdEn) begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      hp_ptr_q  <= '0;
      lp_ptr_q  <= '0;
      burst_q   <= '0;
      wd_q      <= '0;
      to_q      <= 1'b0;
      to_idx_q  <= '0;
      to_cnt_q  <= '0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      hp_ptr_q  <= hp_ptr_d;
      lp_ptr_q  <= lp_ptr_d;
      burst_q   <= burst_d;
      wd_q      <= wd_d;
      to_q      <= to_d;
      to_idx_q  <= to_idx_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_arb_sched.sv
// Scoreboard bench for apb_arb_sched: stimulus pushes expected grants and
// aborts into queues, a negedge monitor pops and compares as the DUT shows them.
module tb_apb_arb_sched;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [15:0] req_i;
  logic [15:0] hp_mask_i;
  logic        done_i;
  logic [15:0] gnt_o;
  logic [3:0]  gnt_idx_o;
  logic        busy_o;
  logic        timeout_o;
  logic [3:0]  timeout_idx_o;
  logic [7:0]  timeout_cnt_o;

  apb_arb_sched #(
    .NUM_REQ        (16),
    .MAX_HP_BURST   (4),
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (8)
  ) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .req_i         (req_i),
    .hp_mask_i     (hp_mask_i),
    .done_i        (done_i),
    .gnt_o         (gnt_o),
    .gnt_idx_o     (gnt_idx_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .timeout_idx_o (timeout_idx_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  always #5 PCLK = ~PCLK;

  // len/gap of 0 mean "not checked" for that grant.
  typedef struct {
    int idx;
    int len;
    int gap;
  } gnt_exp_t;

  typedef struct {
    int idx;
    int cnt;
  } to_exp_t;

  gnt_exp_t gnt_sb[$];
  to_exp_t  to_sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESETn   = 1'b0;
    req_i     = '0;
    hp_mask_i = '0;
    done_i    = 1'b0;
    tick();
    tick();
    PRESETn = 1'b1;
  endtask

  // Monitor: grant start/end and abort pulses, sampled on the falling edge.
  bit in_grant = 1'b0;
  int hold     = 0;
  int gap      = 0;
  int cur_len  = 0;

  always @(negedge PCLK) begin
    gnt_exp_t e;
    to_exp_t  t;
    if (!PRESETn) begin
      in_grant = 1'b0;
      hold     = 0;
      gap      = 0;
    end else begin
      if (gnt_o != '0) begin
        if (!in_grant) begin
          if (gnt_sb.size() == 0) begin
            check("unexpected_grant", gnt_sb.size(), 1);
            cur_len = 0;
          end else begin
            e = gnt_sb.pop_front();
            check("gnt_idx", gnt_idx_o, e.idx);
            check("gnt_onehot", gnt_o, 32'(1) << e.idx);
            if (e.gap != 0) check("idle_gap", gap, e.gap);
            cur_len = e.len;
          end
          in_grant = 1'b1;
          hold     = 0;
        end
        hold++;
      end else begin
        if (in_grant) begin
          if (cur_len != 0) check("grant_len", hold, cur_len);
          in_grant = 1'b0;
          gap      = 0;
        end
        gap++;
      end
      if (timeout_o) begin
        if (to_sb.size() == 0) begin
          check("unexpected_timeout", to_sb.size(), 1);
        end else begin
          t = to_sb.pop_front();
          check("timeout_idx", timeout_idx_o, t.idx);
          check("timeout_cnt", timeout_cnt_o, t.cnt);
          check("timeout_gnt_clear", gnt_o, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int seq3 [10];
    seq3 = '{4, 5, 6, 7, 0, 4, 5, 6, 7, 0};

    PRESETn   = 1'b0;
    req_i     = '0;
    hp_mask_i = '0;
    done_i    = 1'b0;
    tick();
    tick();
    check("rst_gnt", gnt_o, 0);
    check("rst_gnt_idx", gnt_idx_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_timeout_idx", timeout_idx_o, 0);
    check("rst_timeout_cnt", timeout_cnt_o, 0);
    PRESETn = 1'b1;

    // Single request, one-cycle latency, done releases on next edge.
    req_i = 16'h0001;
    gnt_sb.push_back('{idx: 0, len: 1, gap: 0});
    tick();
    check("t1_gnt", gnt_o, 16'h0001);
    check("t1_busy", busy_o, 1);
    req_i  = '0;
    done_i = 1'b1;
    tick();
    check("t1_release_gnt", gnt_o, 0);
    check("t1_release_busy", busy_o, 0);
    done_i = 1'b0;

    // All low priority: plain round robin with one idle cycle between grants.
    do_reset();
    req_i  = 16'hFFFF;
    done_i = 1'b1;
    for (int i = 0; i < 17; i++) gnt_sb.push_back('{idx: i % 16, len: 1, gap: (i == 0) ? 0 : 1});
    repeat (34) tick();
    req_i  = '0;
    done_i = 1'b0;
    repeat (3) tick();

    // High-priority burst bounded to 4 while master 0 waits.
    do_reset();
    hp_mask_i = 16'h00F0;
    req_i     = 16'h00F1;
    done_i    = 1'b1;
    for (int i = 0; i < 10; i++) gnt_sb.push_back('{idx: seq3[i], len: 1, gap: (i == 0) ? 0 : 1});
    repeat (20) tick();
    req_i     = '0;
    done_i    = 1'b0;
    hp_mask_i = '0;
    repeat (3) tick();

    // Watchdog abort after exactly 8 grant cycles.
    do_reset();
    req_i = 16'h0008;
    gnt_sb.push_back('{idx: 3, len: 8, gap: 0});
    to_sb.push_back('{idx: 3, cnt: 1});
    tick();
    req_i = '0;
    check("t4_busy_start", busy_o, 1);
    repeat (7) tick();
    check("t4_busy_last", busy_o, 1);
    tick();
    check("t4_abort_gnt", gnt_o, 0);
    check("t4_abort_pulse", timeout_o, 1);
    check("t4_abort_idx", timeout_idx_o, 3);
    check("t4_abort_cnt", timeout_cnt_o, 1);
    tick();
    check("t4_pulse_single", timeout_o, 0);

    // done on the final permitted cycle wins over expiry.
    req_i = 16'h0008;
    gnt_sb.push_back('{idx: 3, len: 8, gap: 0});
    tick();
    req_i = '0;
    repeat (7) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("t5_done_gnt", gnt_o, 0);
    check("t5_done_no_pulse", timeout_o, 0);
    check("t5_done_cnt", timeout_cnt_o, 1);
    tick();
    check("t5_done_no_late_pulse", timeout_o, 0);

    // Many aborts: counter saturates at all-ones.
    for (int k = 0; k < 256; k++) begin
      req_i = 16'(1) << (k % 16);
      gnt_sb.push_back('{idx: k % 16, len: 8, gap: 0});
      to_sb.push_back('{idx: k % 16, cnt: ((2 + k) > 255) ? 255 : (2 + k)});
      tick();
      req_i = '0;
      repeat (8) tick();
    end
    tick();
    check("t5_cnt_saturated", timeout_cnt_o, 255);

    // Asynchronous reset mid-grant, then re-grant of the same master.
    do_reset();
    req_i = 16'h0200;
    gnt_sb.push_back('{idx: 9, len: 0, gap: 0});
    tick();
    check("t6_gnt", gnt_o, 16'h0200);
    tick();
    tick();
    PRESETn = 1'b0;
    #1;
    check("t6_async_gnt", gnt_o, 0);
    check("t6_async_busy", busy_o, 0);
    check("t6_async_timeout", timeout_o, 0);
    tick();
    PRESETn = 1'b1;
    gnt_sb.push_back('{idx: 9, len: 1, gap: 0});
    tick();
    check("t6_regrant_gnt", gnt_o, 16'h0200);
    check("t6_regrant_idx", gnt_idx_o, 9);
    req_i  = '0;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    repeat (3) tick();

    check("sb_grants_drained", gnt_sb.size(), 0);
    check("sb_timeouts_drained", to_sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
